// File: rtl/easyaxi_rd_slv_if.sv
// AR/R channel bundle between the EasyAXI read master and the read slave.
// Signals: arvalid/arready/arid/araddr/arlen/arsize/arburst (AR request),
//          rvalid/rready/rid/rdata/rresp/rlast (R beat).
// The master modport drives AR and rready; the slave modport drives arready and R.

`ifndef AXI_ID_W
`define AXI_ID_W 4
`endif
`ifndef AXI_ADDR_W
`define AXI_ADDR_W 32
`endif
`ifndef AXI_LEN_W
`define AXI_LEN_W 8
`endif
`ifndef AXI_SIZE_W
`define AXI_SIZE_W 3
`endif
`ifndef AXI_BURST_W
`define AXI_BURST_W 2
`endif
`ifndef AXI_DATA_W
`define AXI_DATA_W 32
`endif
`ifndef AXI_RESP_W
`define AXI_RESP_W 2
`endif

interface easyaxi_rd_slv_if;
    logic                    arvalid;
    logic                    arready;
    logic [`AXI_ID_W-1:0]    arid;
    logic [`AXI_ADDR_W-1:0]  araddr;
    logic [`AXI_LEN_W-1:0]   arlen;
    logic [`AXI_SIZE_W-1:0]  arsize;
    logic [`AXI_BURST_W-1:0] arburst;
    logic                    rvalid;
    logic                    rready;
    logic [`AXI_ID_W-1:0]    rid;
    logic [`AXI_DATA_W-1:0]  rdata;
    logic [`AXI_RESP_W-1:0]  rresp;
    logic                    rlast;

    modport master (
        output arvalid, arid, araddr, arlen, arsize, arburst, rready,
        input  arready, rvalid, rid, rdata, rresp, rlast
    );

    modport slave (
        input  arvalid, arid, araddr, arlen, arsize, arburst, rready,
        output arready, rvalid, rid, rdata, rresp, rlast
    );
endinterface

// File: rtl/easyaxi_rd_slv.sv
// AXI read slave / memory model: queues AR requests in an in-order FIFO and
// returns each burst (FIXED/INCR/WRAP) with address-derived data.
// Ports: clk, rst_n (async active-low), axi_slv (slave modport: AR in, R out),
//        idle (FIFO empty and no burst in flight).

`ifndef AXI_ID_W
`define AXI_ID_W 4
`endif
`ifndef AXI_ADDR_W
`define AXI_ADDR_W 32
`endif
`ifndef AXI_LEN_W
`define AXI_LEN_W 8
`endif
`ifndef AXI_SIZE_W
`define AXI_SIZE_W 3
`endif
`ifndef AXI_BURST_W
`define AXI_BURST_W 2
`endif
`ifndef AXI_DATA_W
`define AXI_DATA_W 32
`endif
`ifndef AXI_RESP_W
`define AXI_RESP_W 2
`endif

module easyaxi_rd_slv #(
    parameter int unsigned               OST_DEPTH  = 4,
    parameter logic [`AXI_ADDR_W-1:0]    ADDR_LIMIT = 'h1000,
    parameter logic [`AXI_DATA_W-1:0]    DATA_SEED  = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    easyaxi_rd_slv_if.slave       axi_slv,
    output logic                  idle
);

    localparam int unsigned ID_W     = `AXI_ID_W;
    localparam int unsigned ADDR_W   = `AXI_ADDR_W;
    localparam int unsigned LEN_W    = `AXI_LEN_W;
    localparam int unsigned SIZE_W   = `AXI_SIZE_W;
    localparam int unsigned BURST_W  = `AXI_BURST_W;
    localparam int unsigned DATA_W   = `AXI_DATA_W;
    localparam int unsigned RESP_W   = `AXI_RESP_W;
    localparam int unsigned PTR_W    = $clog2(OST_DEPTH);
    localparam int unsigned CNT_W    = PTR_W + 1;
    localparam int unsigned MAX_SIZE = $clog2(DATA_W / 8);

    localparam logic [BURST_W-1:0] BURST_FIXED = BURST_W'(0);
    localparam logic [BURST_W-1:0] BURST_WRAP  = BURST_W'(2);
    localparam logic [BURST_W-1:0] BURST_RSVD  = BURST_W'(3);
    localparam logic [RESP_W-1:0]  RESP_OKAY   = RESP_W'(0);
    localparam logic [RESP_W-1:0]  RESP_SLVERR = RESP_W'(2);
    localparam logic [RESP_W-1:0]  RESP_DECERR = RESP_W'(3);

    typedef enum logic [0:0] {S_IDLE, S_BURST} state_t;

    typedef struct packed {
        logic [ID_W-1:0]    id;
        logic [ADDR_W-1:0]  addr;
        logic [LEN_W-1:0]   len;
        logic [SIZE_W-1:0]  size;
        logic [BURST_W-1:0] burst;
    } ar_req_t;

    ar_req_t             fifo_q [OST_DEPTH];
    logic [PTR_W-1:0]    wptr_q, rptr_q;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                arready_q, arready_d;
    logic                idle_q, idle_d;
    logic                push, pop;
    ar_req_t             head, push_req;

    state_t              state_q, state_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [SIZE_W-1:0]   size_q, size_d;
    logic [BURST_W-1:0]  burst_q, burst_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic [RESP_W-1:0]   resp_q, resp_d;
    logic                rvalid_q, rvalid_d;
    logic                rlast_q, rlast_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [ADDR_W-1:0]   nxt_addr;

    // Address of the beat following addr within the current burst.
    function automatic logic [ADDR_W-1:0] next_addr(
        input logic [ADDR_W-1:0]  addr,
        input logic [LEN_W-1:0]   len,
        input logic [SIZE_W-1:0]  size,
        input logic [BURST_W-1:0] burst
    );
        logic [ADDR_W-1:0] bytes, incr, wrap_bytes, lower;
        bytes      = ADDR_W'(1) << size;
        incr       = (addr & ~(bytes - ADDR_W'(1))) + bytes;
        wrap_bytes = bytes * (ADDR_W'(len) + ADDR_W'(1));
        lower      = addr & ~(wrap_bytes - ADDR_W'(1));
        if (burst == BURST_FIXED)
            next_addr = addr;
        else if (burst == BURST_WRAP)
            next_addr = (incr == lower + wrap_bytes) ? lower : incr;
        else
            next_addr = incr;
    endfunction

    // One response code for the whole burst; decode error takes priority.
    function automatic logic [RESP_W-1:0] classify(input ar_req_t req);
        logic wrap_len_ok;
        wrap_len_ok = (req.len == LEN_W'(1)) || (req.len == LEN_W'(3)) ||
                      (req.len == LEN_W'(7)) || (req.len == LEN_W'(15));
        if (req.addr >= ADDR_LIMIT)
            classify = RESP_DECERR;
        else if ((req.burst == BURST_RSVD) || (req.size > SIZE_W'(MAX_SIZE)) ||
                 ((req.burst == BURST_WRAP) && !wrap_len_ok))
            classify = RESP_SLVERR;
        else
            classify = RESP_OKAY;
    endfunction

    assign push_req = '{id: axi_slv.arid, addr: axi_slv.araddr, len: axi_slv.arlen,
                        size: axi_slv.arsize, burst: axi_slv.arburst};
    assign push     = axi_slv.arvalid & arready_q;
    assign head     = fifo_q[rptr_q];
    assign nxt_addr = next_addr(addr_q, len_q, size_q, burst_q);

    // FIFO payload storage needs no reset: occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push) fifo_q[wptr_q] <= push_req;
    end

    // Next-state: pop into the burst registers when idle or on a last beat.
    always_comb begin
        logic load, advance;
        state_d  = state_q;
        id_d     = id_q;
        addr_d   = addr_q;
        len_d    = len_q;
        size_d   = size_q;
        burst_d  = burst_q;
        cnt_d    = cnt_q;
        resp_d   = resp_q;
        rvalid_d = rvalid_q;
        rlast_d  = rlast_q;
        rdata_d  = rdata_q;
        load     = 1'b0;
        advance  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (count_q != '0) load = 1'b1;
            end
            S_BURST: begin
                if (rvalid_q && axi_slv.rready) begin
                    if (!rlast_q) begin
                        advance = 1'b1;
                    end else if (count_q != '0) begin
                        load = 1'b1;
                    end else begin
                        state_d  = S_IDLE;
                        rvalid_d = 1'b0;
                        rlast_d  = 1'b0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (load) begin
            state_d  = S_BURST;
            id_d     = head.id;
            addr_d   = head.addr;
            len_d    = head.len;
            size_d   = head.size;
            burst_d  = head.burst;
            cnt_d    = '0;
            resp_d   = classify(head);
            rvalid_d = 1'b1;
            rlast_d  = (head.len == '0);
            rdata_d  = DATA_W'(head.addr) ^ DATA_SEED;
        end
        if (advance) begin
            addr_d  = nxt_addr;
            cnt_d   = cnt_q + LEN_W'(1);
            rlast_d = ((cnt_q + LEN_W'(1)) == len_q);
            rdata_d = DATA_W'(nxt_addr) ^ DATA_SEED;
        end

        pop       = load;
        count_d   = count_q + CNT_W'(push) - CNT_W'(pop);
        arready_d = (count_d != CNT_W'(OST_DEPTH));
        idle_d    = (count_d == '0) && (state_d == S_IDLE);
    end

    // State, FIFO bookkeeping and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            arready_q <= 1'b1;
            idle_q    <= 1'b1;
            id_q      <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            size_q    <= '0;
            burst_q   <= '0;
            cnt_q     <= '0;
            resp_q    <= '0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            if (push) wptr_q <= wptr_q + PTR_W'(1);
            if (pop)  rptr_q <= rptr_q + PTR_W'(1);
            count_q   <= count_d;
            arready_q <= arready_d;
            idle_q    <= idle_d;
            id_q      <= id_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            size_q    <= size_d;
            burst_q   <= burst_d;
            cnt_q     <= cnt_d;
            resp_q    <= resp_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rdata_q   <= rdata_d;
        end
    end

    assign axi_slv.arready = arready_q;
    assign axi_slv.rvalid  = rvalid_q;
    assign axi_slv.rid     = id_q;
    assign axi_slv.rdata   = rdata_q;
    assign axi_slv.rresp   = resp_q;
    assign axi_slv.rlast   = rlast_q;
    assign idle            = idle_q;

endmodule

// File: tb/tb_easyaxi_rd_slv.sv
// Self-checking bench for easyaxi_rd_slv: expected R beats are pushed to a
// scoreboard when each AR is accepted and compared as the slave returns them.

`ifndef AXI_ID_W
`define AXI_ID_W 4
`endif
`ifndef AXI_ADDR_W
`define AXI_ADDR_W 32
`endif
`ifndef AXI_DATA_W
`define AXI_DATA_W 32
`endif

module tb_easyaxi_rd_slv;
    localparam int unsigned ID_W   = `AXI_ID_W;
    localparam int unsigned ADDR_W = `AXI_ADDR_W;
    localparam int unsigned DATA_W = `AXI_DATA_W;
    localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(32'h1000);
    localparam logic [DATA_W-1:0] SEED  = DATA_W'(32'hC3C3_0F0F);

    typedef struct {
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] data;
        logic [1:0]        resp;
        logic              last;
    } beat_t;

    logic  clk = 1'b0;
    logic  rst_n = 1'b0;
    logic  idle;
    int    checks = 0;
    int    errors = 0;
    int    beats  = 0;
    beat_t sb [$];

    easyaxi_rd_slv_if axi();

    easyaxi_rd_slv #(
        .OST_DEPTH (4),
        .ADDR_LIMIT(LIMIT),
        .DATA_SEED (SEED)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .axi_slv(axi),
        .idle   (idle)
    );

    always #5 clk = ~clk;

    // Reference model: beat addresses computed as offsets from the burst start.
    // Illegal-length WRAP bursts used here start on a wrap boundary, so they
    // step like INCR; reserved bursts are only issued with a single beat.
    task automatic push_burst(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr,
                              input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
        logic [ADDR_W-1:0] nb, wb, lower, a;
        logic [1:0]        resp;
        logic              wrap_ok;
        beat_t             b;
        nb      = ADDR_W'(1) << size;
        wrap_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        if (addr >= LIMIT) resp = 2'b11;
        else if (burst == 2'b11 || size > 3'd2 || (burst == 2'b10 && !wrap_ok)) resp = 2'b10;
        else resp = 2'b00;
        wb    = nb * (ADDR_W'(len) + ADDR_W'(1));
        lower = addr & ~(wb - ADDR_W'(1));
        for (int i = 0; i <= int'(len); i++) begin
            if (burst == 2'b00) a = addr;
            else if (burst == 2'b10 && wrap_ok) a = lower + ((addr - lower + ADDR_W'(i) * nb) % wb);
            else if (i == 0) a = addr;
            else a = (addr & ~(nb - ADDR_W'(1))) + ADDR_W'(i) * nb;
            b.id   = id;
            b.data = DATA_W'(a) ^ SEED;
            b.resp = resp;
            b.last = (i == int'(len));
            sb.push_back(b);
        end
    endtask

    // Issue one AR; called just after a rising edge, returns just after the handshake edge.
    task automatic send_ar(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr,
                           input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
        int n;
        axi.arvalid = 1'b1;
        axi.arid    = id;
        axi.araddr  = addr;
        axi.arlen   = len;
        axi.arsize  = size;
        axi.arburst = burst;
        n = 0;
        @(negedge clk);
        while (!axi.arready && n < 200) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (!axi.arready) begin
            errors++;
            $display("FAIL ar_accept id=%0d: arready=%b, required 1 within 200 cycles", id, axi.arready);
        end else begin
            push_burst(id, addr, len, size, burst);
        end
        @(posedge clk);
        #1;
        axi.arvalid = 1'b0;
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(posedge clk);
            #2;
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d beats outstanding, required 0 within %0d cycles", name, sb.size(), budget);
            sb.delete();
        end
    endtask

    // Scoreboard monitor and stall-stability checker, sampled on the falling edge.
    logic              held_v = 1'b0;
    logic [ID_W-1:0]   held_id;
    logic [DATA_W-1:0] held_data;
    logic [1:0]        held_resp;
    logic              held_last;

    always @(negedge clk) begin
        beat_t e;
        if (!rst_n) begin
            held_v = 1'b0;
        end else begin
            if (held_v) begin
                checks++;
                if ({axi.rvalid, axi.rid, axi.rdata, axi.rresp, axi.rlast} !==
                    {1'b1, held_id, held_data, held_resp, held_last}) begin
                    errors++;
                    $display("FAIL stall_stable: got v=%b id=%0d data=%h resp=%0d last=%b, required v=1 id=%0d data=%h resp=%0d last=%b",
                             axi.rvalid, axi.rid, axi.rdata, axi.rresp, axi.rlast,
                             held_id, held_data, held_resp, held_last);
                end
            end
            held_v    = axi.rvalid && !axi.rready;
            held_id   = axi.rid;
            held_data = axi.rdata;
            held_resp = axi.rresp;
            held_last = axi.rlast;
            if (axi.rvalid && axi.rready) begin
                beats++;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat: got id=%0d data=%h, required no beat", axi.rid, axi.rdata);
                end else begin
                    e = sb.pop_front();
                    if (axi.rid !== e.id || axi.rdata !== e.data || axi.rresp !== e.resp || axi.rlast !== e.last) begin
                        errors++;
                        $display("FAIL beat: got id=%0d data=%h resp=%0d last=%b, required id=%0d data=%h resp=%0d last=%b",
                                 axi.rid, axi.rdata, axi.rresp, axi.rlast, e.id, e.data, e.resp, e.last);
                    end
                end
            end
        end
    end

    task automatic test_reset();
        axi.arvalid = 1'b0; axi.arid = '0; axi.araddr = '0; axi.arlen = '0;
        axi.arsize = '0; axi.arburst = '0; axi.rready = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({axi.rvalid, axi.rlast, axi.rid, axi.rdata, axi.rresp, axi.arready, idle} !==
            {1'b0, 1'b0, ID_W'(0), DATA_W'(0), 2'b00, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL reset_values: got rvalid=%b rlast=%b rid=%0d rdata=%h rresp=%0d arready=%b idle=%b, required 0 0 0 0 0 1 1",
                     axi.rvalid, axi.rlast, axi.rid, axi.rdata, axi.rresp, axi.arready, idle);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({axi.rvalid, axi.arready, idle} !== 3'b011) begin
            errors++;
            $display("FAIL post_reset_idle: got rvalid=%b arready=%b idle=%b, required 0 1 1", axi.rvalid, axi.arready, idle);
        end
    endtask

    task automatic test_incr();
        axi.rready = 1'b1;
        send_ar(ID_W'(1), ADDR_W'(32'h10), 8'd3, 3'd2, 2'b01);
        checks++;
        if (axi.rvalid !== 1'b0) begin
            errors++;
            $display("FAIL incr_latency_early: rvalid=%b one cycle after AR, required 0", axi.rvalid);
        end
        @(posedge clk);
        #1;
        checks++;
        if (axi.rvalid !== 1'b1 || axi.rid !== ID_W'(1) || axi.rdata !== (DATA_W'(32'h10) ^ SEED)) begin
            errors++;
            $display("FAIL incr_latency: rvalid=%b rid=%0d rdata=%h two cycles after AR, required 1 1 %h",
                     axi.rvalid, axi.rid, axi.rdata, DATA_W'(32'h10) ^ SEED);
        end
        wait_drain(50, "incr");
        checks++;
        if (axi.rvalid !== 1'b0 || idle !== 1'b1) begin
            errors++;
            $display("FAIL incr_end_idle: rvalid=%b idle=%b, required 0 1", axi.rvalid, idle);
        end
    endtask

    task automatic test_wrap();
        axi.rready = 1'b1;
        send_ar(ID_W'(2), ADDR_W'(32'h34), 8'd3, 3'd2, 2'b10);
        send_ar(ID_W'(3), ADDR_W'(32'h38), 8'd7, 3'd2, 2'b10);
        wait_drain(80, "wrap");
    endtask

    task automatic test_fixed_err();
        axi.rready = 1'b1;
        send_ar(ID_W'(4), ADDR_W'(32'h30), 8'd7, 3'd2, 2'b00);
        send_ar(ID_W'(5), ADDR_W'(32'h40), 8'd2, 3'd2, 2'b10);
        send_ar(ID_W'(6), ADDR_W'(32'h50), 8'd0, 3'd2, 2'b11);
        send_ar(ID_W'(7), ADDR_W'(32'h48), 8'd0, 3'd3, 2'b01);
        send_ar(ID_W'(8), ADDR_W'(32'h1000), 8'd3, 3'd2, 2'b01);
        send_ar(ID_W'(9), ADDR_W'(32'hFFC), 8'd1, 3'd2, 2'b01);
        wait_drain(150, "fixed_err");
    endtask

    task automatic test_back_to_back();
        int gaps, n;
        axi.rready = 1'b0;
        send_ar(ID_W'(4), ADDR_W'(32'h200), 8'd0, 3'd2, 2'b01);
        send_ar(ID_W'(5), ADDR_W'(32'h210), 8'd1, 3'd2, 2'b01);
        send_ar(ID_W'(6), ADDR_W'(32'h248), 8'd3, 3'd2, 2'b10);
        send_ar(ID_W'(7), ADDR_W'(32'h260), 8'd2, 3'd2, 2'b00);
        checks++;
        if (axi.arready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_not_full: arready=%b with 3 queued, required 1", axi.arready);
        end
        send_ar(ID_W'(8), ADDR_W'(32'h300), 8'd0, 3'd2, 2'b01);
        checks++;
        if (axi.arready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_full: arready=%b with 4 queued, required 0", axi.arready);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (axi.arready !== 1'b0 || axi.rvalid !== 1'b1 || axi.rid !== ID_W'(4)) begin
            errors++;
            $display("FAIL b2b_stalled: arready=%b rvalid=%b rid=%0d, required 0 1 4", axi.arready, axi.rvalid, axi.rid);
        end
        axi.rready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (axi.arready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_arready_reassert: arready=%b after first pop, required 1", axi.arready);
        end
        gaps = 0;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            if (!axi.rvalid) gaps++;
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (sb.size() != 0 || gaps != 0) begin
            errors++;
            $display("FAIL b2b_no_bubble: outstanding=%0d idle_cycles=%0d, required 0 0", sb.size(), gaps);
            sb.delete();
        end
        checks++;
        if (idle !== 1'b1 || axi.rvalid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end_idle: idle=%b rvalid=%b, required 1 0", idle, axi.rvalid);
        end
    endtask

    task automatic test_stall();
        int start_beats, n;
        axi.rready = 1'b0;
        start_beats = beats;
        send_ar(ID_W'(10), ADDR_W'(32'h100), 8'd7, 3'd2, 2'b01);
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            axi.rready = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            n++;
        end
        axi.rready = 1'b1;
        wait_drain(20, "stall");
        checks++;
        if (beats - start_beats != 8) begin
            errors++;
            $display("FAIL stall_beat_count: got %0d beats, required 8", beats - start_beats);
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        axi.rready = 1'b0;
        send_ar(ID_W'(11), ADDR_W'(32'h400), 8'd7, 3'd2, 2'b01);
        send_ar(ID_W'(12), ADDR_W'(32'h500), 8'd3, 3'd2, 2'b01);
        @(posedge clk);
        #1;
        axi.rready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        axi.rready = 1'b0;
        rst_n = 1'b0;
        #1;
        sb.delete();
        checks++;
        if ({axi.rvalid, axi.arready, idle, axi.rlast} !== 4'b0110) begin
            errors++;
            $display("FAIL reset_mid: rvalid=%b arready=%b idle=%b rlast=%b, required 0 1 1 0",
                     axi.rvalid, axi.arready, idle, axi.rlast);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        axi.rready = 1'b1;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (axi.rvalid) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL reset_discard: %0d cycles with rvalid after reset, required 0", seen);
        end
    endtask

    task automatic test_post_reset();
        @(posedge clk);
        #1;
        axi.rready = 1'b1;
        send_ar(ID_W'(13), ADDR_W'(32'h44), 8'd1, 3'd2, 2'b01);
        wait_drain(30, "post_reset");
        checks++;
        if (idle !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_idle_end: idle=%b, required 1", idle);
        end
    endtask

    initial begin
        test_reset();
        test_incr();
        test_wrap();
        test_fixed_err();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        test_post_reset();
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
